// File: rtl/vga_out.sv
// 640x480@60 monochrome VGA scan-out: sync timing, double-buffered SRAM word fetch
// and 1-bpp serialisation of a 128x96 frame buffer scaled 5x in both axes.
//
// fetch state | meaning
// F_IDLE      | no request outstanding, waits for a scheduled fetch
// F_READ      | first request cycle, address just latched
// F_WAIT      | SRAM busy, request and address held
// F_ILL       | unreachable, recovers to F_IDLE
module vga_out (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] SRAM_data_in,
  input  logic        SRAM_busy,
  output logic        data_en,
  output logic [31:0] word_address_dest,
  output logic [3:0]  byte_select,
  output logic        h_out,
  output logic        v_out,
  output logic        pixel_data,
  output logic [1:0]  VGA_state,
  output logic [9:0]  h_count,
  output logic [8:0]  v_count,
  output logic [1:0]  h_state,
  output logic [1:0]  v_state
);

  typedef enum logic [1:0] {H_SYNC, H_PORCH_A, H_ACTIVE, H_PORCH_B} h_state_e;
  typedef enum logic [1:0] {V_SYNC, V_PORCH_A, V_ACTIVE, V_PORCH_B} v_state_e;
  typedef enum logic [1:0] {F_IDLE, F_READ, F_WAIT, F_ILL} fetch_state_e;

  h_state_e     h_state_q, h_state_d;
  v_state_e     v_state_q, v_state_d;
  fetch_state_e fetch_q, fetch_d;
  logic [9:0]   h_count_q, h_count_d;
  logic [8:0]   v_count_q, v_count_d;
  logic [10:0]  addr_q, addr_d;
  logic [31:0]  cur_word_q, cur_word_d;
  logic [31:0]  nxt_word_q, nxt_word_d;

  logic [9:0]   h_last;
  logic [8:0]   v_last;
  logic         line_end;
  logic [9:0]   fx;
  logic [8:0]   fy;
  logic [10:0]  row_base;
  logic         sched;
  logic [10:0]  sched_addr;
  logic         swap;

  always_comb begin
    h_last = 10'd15;
    case (h_state_q)
      H_SYNC:    h_last = 10'd95;
      H_PORCH_A: h_last = 10'd47;
      H_ACTIVE:  h_last = 10'd639;
      default:   h_last = 10'd15;
    endcase
    v_last = 9'd9;
    case (v_state_q)
      V_SYNC:    v_last = 9'd1;
      V_PORCH_A: v_last = 9'd32;
      V_ACTIVE:  v_last = 9'd479;
      default:   v_last = 9'd9;
    endcase
  end

  assign line_end = (h_state_q == H_PORCH_B) && (h_count_q == 10'd15);

  always_comb begin
    h_state_d = h_state_q;
    h_count_d = h_count_q + 10'd1;
    if (h_count_q == h_last) begin
      h_count_d = 10'd0;
      h_state_d = h_state_e'(h_state_q + 2'd1);
    end
    v_state_d = v_state_q;
    v_count_d = v_count_q;
    if (line_end) begin
      if (v_count_q == v_last) begin
        v_count_d = 9'd0;
        v_state_d = v_state_e'(v_state_q + 2'd1);
      end else begin
        v_count_d = v_count_q + 9'd1;
      end
    end
  end

  assign fx       = h_count_q / 10'd5;
  assign fy       = v_count_q / 9'd5;
  assign row_base = {fy, 2'b00};

  // Fetch the next word at the start of each 160-cycle group so it is ready by the swap.
  always_comb begin
    sched      = 1'b0;
    sched_addr = row_base;
    if (v_state_q == V_ACTIVE) begin
      if (h_state_q == H_PORCH_A && h_count_q == 10'd0) begin
        sched = 1'b1;
      end else if (h_state_q == H_ACTIVE &&
                   (h_count_q == 10'd0 || h_count_q == 10'd160 || h_count_q == 10'd320)) begin
        sched      = 1'b1;
        sched_addr = row_base + {6'd0, fx[9:5]} + 11'd1;
      end
    end
  end

  assign swap = (h_state_q == H_PORCH_A && h_count_q == 10'd47) ||
                (h_state_q == H_ACTIVE &&
                 (h_count_q == 10'd159 || h_count_q == 10'd319 || h_count_q == 10'd479));

  // A fetch scheduled while another is still outstanding is dropped; timing never stalls.
  always_comb begin
    fetch_d    = fetch_q;
    addr_d     = addr_q;
    nxt_word_d = nxt_word_q;
    cur_word_d = swap ? nxt_word_q : cur_word_q;
    data_en    = 1'b0;
    case (fetch_q)
      F_IDLE: begin
        if (sched) begin
          fetch_d = F_READ;
          addr_d  = sched_addr;
        end
      end
      F_READ, F_WAIT: begin
        data_en = 1'b1;
        if (!SRAM_busy) begin
          nxt_word_d = SRAM_data_in;
          fetch_d    = F_IDLE;
        end else begin
          fetch_d = F_WAIT;
        end
      end
      default: fetch_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      h_state_q  <= H_SYNC;
      v_state_q  <= V_SYNC;
      h_count_q  <= 10'd0;
      v_count_q  <= 9'd0;
      fetch_q    <= F_IDLE;
      addr_q     <= 11'd0;
      cur_word_q <= 32'd0;
      nxt_word_q <= 32'd0;
    end else begin
      h_state_q  <= h_state_d;
      v_state_q  <= v_state_d;
      h_count_q  <= h_count_d;
      v_count_q  <= v_count_d;
      fetch_q    <= fetch_d;
      addr_q     <= addr_d;
      cur_word_q <= cur_word_d;
      nxt_word_q <= nxt_word_d;
    end
  end

  assign word_address_dest = {21'd0, addr_q};
  assign byte_select       = data_en ? 4'b1111 : 4'b0000;
  assign h_out             = (h_state_q != H_SYNC);
  assign v_out             = (v_state_q != V_SYNC);
  assign pixel_data        = (h_state_q == H_ACTIVE && v_state_q == V_ACTIVE) ?
                             cur_word_q[fx[4:0]] : 1'b0;
  assign VGA_state         = fetch_q;
  assign h_count           = h_count_q;
  assign v_count           = v_count_q;
  assign h_state           = h_state_q;
  assign v_state           = v_state_q;

endmodule

// File: tb/tb_vga_out.sv
// Bench for vga_out: position-based timing/pixel model, fetch-address scoreboard,
// SRAM busy stall and mid-fetch reset.
module tb_vga_out;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        SRAM_busy = 1'b0;
  logic [31:0] SRAM_data_in;
  logic        data_en;
  logic [31:0] word_address_dest;
  logic [3:0]  byte_select;
  logic        h_out, v_out, pixel_data;
  logic [1:0]  VGA_state;
  logic [9:0]  h_count;
  logic [8:0]  v_count;
  logic [1:0]  h_state, v_state;

  vga_out dut (
    .clk(clk), .nrst(nrst), .SRAM_data_in(SRAM_data_in), .SRAM_busy(SRAM_busy),
    .data_en(data_en), .word_address_dest(word_address_dest), .byte_select(byte_select),
    .h_out(h_out), .v_out(v_out), .pixel_data(pixel_data), .VGA_state(VGA_state),
    .h_count(h_count), .v_count(v_count), .h_state(h_state), .v_state(v_state)
  );

  always #20 clk = ~clk;

  logic [31:0] mem [0:383];
  assign SRAM_data_in = SRAM_busy ? 32'hDEAD_BEEF :
                        (word_address_dest < 32'd384 ? mem[word_address_dest[8:0]] : 32'd0);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int hpos, line;
  int err_t, err_sync, err_pix, err_de, err_busy, err_sb;
  int ones, vlow, pops, nwait;
  int bk;
  bit busy_en, busy_done;
  logic [31:0] baddr;
  logic [31:0] sb[$];

  function automatic int hs(input int p);
    if (p < 96) return 0;
    if (p < 144) return 1;
    if (p < 784) return 2;
    return 3;
  endfunction

  function automatic int h_start(input int s);
    case (s)
      0: return 0;
      1: return 96;
      2: return 144;
      default: return 784;
    endcase
  endfunction

  function automatic int vs(input int l);
    if (l < 2) return 0;
    if (l < 35) return 1;
    if (l < 515) return 2;
    return 3;
  endfunction

  function automatic int v_start(input int s);
    case (s)
      0: return 0;
      1: return 2;
      2: return 35;
      default: return 515;
    endcase
  endfunction

  task automatic clear_stats();
    err_t = 0; err_sync = 0; err_pix = 0; err_de = 0; err_busy = 0; err_sb = 0;
    ones = 0; pops = 0; nwait = 0; bk = -1; busy_done = 0;
    sb.delete();
  endtask

  task automatic step();
    int eh, ev, x, y, w;
    bit vis, act;
    logic [31:0] wv;
    logic exp_pix;
    @(negedge clk);
    hpos++;
    if (hpos == 800) begin
      hpos = 0;
      line = (line == 524) ? 0 : line + 1;
    end
    eh = hs(hpos);
    ev = vs(line);
    if (int'(h_state) != eh || int'(h_count) != hpos - h_start(eh)) err_t++;
    if (int'(v_state) != ev || int'(v_count) != line - v_start(ev)) err_t++;
    if (h_out !== (eh != 0) || v_out !== (ev != 0)) err_sync++;
    if (v_out === 1'b0) vlow++;
    vis = (ev == 2);
    act = vis && (eh == 2);
    exp_pix = 1'b0;
    if (act) begin
      x = hpos - 144;
      y = line - 35;
      w = (y / 5) * 4 + (x / 5) / 32;
      wv = mem[w];
      exp_pix = wv[(x / 5) % 32];
    end
    if (pixel_data !== exp_pix) err_pix++;
    if (pixel_data === 1'b1) ones++;
    if (data_en && !vis) err_de++;
    if (byte_select !== (data_en ? 4'hF : 4'h0)) err_de++;

    if (bk >= 0) begin
      bk++;
      if (bk <= 10) begin
        if (VGA_state !== 2'd2 || data_en !== 1'b1 || word_address_dest !== baddr) err_busy++;
        if (VGA_state === 2'd2) nwait++;
        if (bk == 10) SRAM_busy = 1'b0;
      end else begin
        if (VGA_state !== 2'd0) err_busy++;
        bk = -1;
        busy_done = 1;
      end
    end else if (busy_en && !busy_done && line == 37 && VGA_state == 2'd1) begin
      bk = 0;
      baddr = word_address_dest;
      SRAM_busy = 1'b1;
    end

    if (vis && (hpos == 96 || hpos == 144 || hpos == 304 || hpos == 464))
      sb.push_back(((line - 35) / 5) * 4 + (hpos == 96 ? 0 : (hpos - 144) / 160 + 1));
    if (data_en === 1'b1 && SRAM_busy === 1'b0) begin
      pops++;
      if (sb.size() == 0) err_sb++;
      else chk("fetch_addr", word_address_dest, sb.pop_front());
    end
  endtask

  task automatic release_reset();
    nrst = 1'b1;
    hpos = 0;
    line = 0;
    vlow = (v_out === 1'b0) ? 1 : 0;
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 384; i++) mem[i] = 32'hFFFF_FFFF;
    clear_stats();
    busy_en = 0;

    // Phase A: reset values, free-run timing, all-ones frame buffer
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_h_count", h_count, 0);
    chk("rst_v_count", v_count, 0);
    chk("rst_h_state", h_state, 0);
    chk("rst_v_state", v_state, 0);
    chk("rst_vga_state", VGA_state, 0);
    chk("rst_pixel", pixel_data, 0);
    chk("rst_h_out", h_out, 0);
    chk("rst_v_out", v_out, 0);
    chk("rst_data_en", data_en, 0);
    chk("rst_addr", word_address_dest, 0);
    chk("rst_byte_sel", byte_select, 0);
    release_reset();
    step();
    chk("first_edge_hcount", h_count, 1);
    repeat (38 * 800 - 1) step();
    chk("a_timing_errs", err_t, 0);
    chk("a_sync_errs", err_sync, 0);
    chk("a_pixel_errs", err_pix, 0);
    chk("a_lit_pixels", ones, 3 * 640);
    chk("a_vsync_low_clks", vlow, 1600);
    chk("a_data_en_errs", err_de, 0);
    chk("a_fetch_count", pops, 12);
    chk("a_sb_underflow", err_sb, 0);
    chk("a_sb_leftover", sb.size(), 0);

    // Reset while a fetch is outstanding aborts it
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (VGA_state == 2'd1) found = 1;
    end
    chk("find_read", found, 1);
    #5 nrst = 1'b0;
    #1;
    chk("midrst_vga_state", VGA_state, 0);
    chk("midrst_data_en", data_en, 0);
    chk("midrst_h_count", h_count, 0);
    chk("midrst_v_count", v_count, 0);

    // Phase B: single lit pixel in word 0, busy stall on the third visible line
    for (int i = 0; i < 384; i++) mem[i] = 32'd0;
    mem[0] = 32'h0000_0001;
    clear_stats();
    busy_en = 1;
    repeat (2) @(negedge clk);
    release_reset();
    repeat (43 * 800) step();
    chk("b_timing_errs", err_t, 0);
    chk("b_pixel_errs", err_pix, 0);
    chk("b_lit_pixels", ones, 25);
    chk("b_fetch_count", pops, 32);
    chk("b_sb_underflow", err_sb, 0);
    chk("b_sb_leftover", sb.size(), 0);
    chk("b_busy_seen", busy_done, 1);
    chk("b_busy_errs", err_busy, 0);
    chk("b_wait_cycles", nwait, 10);
    chk("b_data_en_errs", err_de, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_out.md
Name: vga_out

Overview:
- Monochrome 640x480@60 Hz VGA timing generator and scan-out engine, driven from the 25 MHz pixel clock.
- Generates HSYNC and VSYNC.
- Fetches frame-buffer words from SRAM through a simple read-request interface.
- Serialises one bit per pixel onto pixel_data.
- The frame buffer is 128x96 bits (384 32-bit words), scaled 5x in both axes to fill 640x480.

Parameters:
- None. All timing values are fixed constants, listed in Behaviour.

Ports:
- clk  in  1  pixel clock, 25 MHz, rising-edge
- nrst  in  1  asynchronous active-low reset
- SRAM_data_in  in  32  read data; valid in a cycle where data_en=1 and SRAM_busy=0
- SRAM_busy  in  1  SRAM cannot service the request this cycle
- data_en  out  1  SRAM read request
- word_address_dest  out  32  word address of the request
- byte_select  out  4  4'b1111 while data_en=1, else 4'b0000
- h_out  out  1  HSYNC, active low
- v_out  out  1  VSYNC, active low
- pixel_data  out  1  video bit, 1 = lit
- VGA_state  out  2  fetch FSM state
- h_count  out  10  cycle count within the current horizontal state
- v_count  out  9  line count within the current vertical state
- h_state  out  2  horizontal state
- v_state  out  2  vertical state

Behaviour:
- Reset (nrst=0, asynchronous) forces the following until release:
  - h_state=0, v_state=0, h_count=0, v_count=0
  - VGA_state=0, data_en=0, byte_select=0, word_address_dest=0
  - pixel_data=0, both internal word buffers=0
- Horizontal FSM. h_count increments every clock.
  - When h_count reaches (length-1) it returns to 0 and h_state advances.
  - States and lengths: 0 SYNC 96 → 1 HPORCH_A 48 → 2 HACTIVE 640 → 3 HPORCH_B 16 → 0 SYNC.
  - Line period is 800 clocks.
  - After reset release, the first edge gives h_count=1.
- Vertical FSM. Advances only on the last cycle of a line (h_state=3 and h_count=15).
  - v_count then increments, or returns to 0 with a state advance at (length-1).
  - States and lengths: 0 VSYNC 2 → 1 VPORCH_A 33 → 2 VACTIVE 480 → 3 VPORCH_B 10 → 0.
  - Frame period is 525 lines.
- Sync outputs (combinational from state):
  - h_out = (h_state != 0)
  - v_out = (v_state != 0)
  - Consequently h_out=0 and v_out=0 during reset.
- Pixel mapping:
  - In h_state=2, x=h_count; in v_state=2, y=v_count.
  - fx = x/5 (0..127), fy = y/5 (0..95).
  - Word address = fy*4 + fx/32 (0..383), zero-extended to 32 bits.
  - Pixel bit = word[fx mod 32] (bit 0 is the leftmost pixel of the word).
- pixel_data (combinational):
  - Equals current_word[fx mod 32] when h_state=2 and v_state=2.
  - Otherwise 0.
- Double buffering (current_word, next_word):
  - During HPORCH_A of each visible line, fetch word fy*4 into next_word.
  - On entering HACTIVE, copy next_word into current_word.
  - When fx mod 32 first reaches 0 in a 160-cycle group, request word fy*4 + fx/32 + 1 (if fx/32 < 3) into next_word.
  - At each 160-pixel group boundary, copy next_word into current_word.
  - No fetches occur outside v_state=2.
- Fetch FSM (VGA_state):
  - 0 IDLE: data_en=0. Moves to 1 when a fetch is scheduled; word_address_dest is latched at that point.
  - 1 READ: data_en=1. If SRAM_busy=0, capture SRAM_data_in into next_word and return to 0. Otherwise go to 2.
  - 2 WAIT: data_en=1 with the address held. When SRAM_busy=0, capture and return to 0.
  - 3 (illegal): goes to 0.
- Late fetch: if a fetch has not completed by the swap point, the swap still occurs and the stale next_word is shown. Timing must not stall.
- SRAM_busy never affects sync timing.
- Reset mid-frame: restarts at SYNC/VSYNC with counts 0 and any pending fetch aborted.

Test Plan:
- Hold nrst=0 for 2 clocks:
  - all outputs at reset values (h_count=0, v_count=0, VGA_state=0, pixel_data=0, h_out=0, v_out=0)
  - one clock after release, h_count=1.
- Free-run one line:
  - h_state=0 for 96 cycles (h_count 0..95), then 1 for 48, 2 for 640, 3 for 16.
  - h_count wraps to 0 at each transition.
  - h_out low only in SYNC.
- Free-run one frame:
  - v_state sequence 0(2 lines), 1(33), 2(480), 3(10).
  - v_count steps on h_state=3,h_count=15.
  - v_out low exactly 1600 clocks.
- Memory all ones, SRAM_busy=0:
  - pixel_data=1 exactly for lines in VACTIVE during HACTIVE (640 cycles per line), 0 elsewhere.
  - data_en pulses only in VACTIVE.
- Memory word 0 = 32'h0000_0001, others 0:
  - in the first visible line, pixel_data=1 only for the first 5 HACTIVE cycles.
  - the same pattern repeats for 5 lines, then stays dark.
  - word_address_dest sequence 0,1,2,3 per line.
- SRAM_busy held high 10 cycles during a READ:
  - VGA_state goes 1→2, data_en and address stay stable.
  - on release the word is captured and the state returns to 0.
  - h/v timing is unchanged.
